ripple_count_sampler: RTL and testbench

Samples the free-running output of the 4-bit ripple (asynchronous) counter into the system clock domain and accumulates its progress into a wide synchronous count. Ripple counters show transient intermediate codes while bits settle, so the block accepts a value only after it has been stable for a programmable number of cycles. It sits directly downstream of the ripple counter and hands snapshots to a consumer over a valid/ready handshake.

---
 rtl/ripple_sampler_pkg.sv | 19 +
 rtl/bit_sync2.sv | 26 ++
 rtl/ripple_count_sampler.sv | 184 ++++++++++++++++++
 tb/tb_ripple_count_sampler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_sampler_pkg.sv
// Shared types and default parameters for the ripple counter sampler.
// Saturating accumulation is selected by defining RIPPLE_SAMPLER_SAT_EN.
package ripple_sampler_pkg;

   localparam int unsigned CNT_W_DEFAULT    = 4;
   localparam int unsigned ACC_W_DEFAULT    = 16;
   localparam int unsigned STABLE_N_DEFAULT = 2;

   typedef enum logic {
      FiltInit,
      FiltRun
   } filt_state_e;

   typedef enum logic {
      SnapIdle,
      SnapHold
   } snap_state_e;

endpackage

// File: rtl/bit_sync2.sv
// Parameterized-width two-flop synchronizer with active-low asynchronous reset.
module bit_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/ripple_count_sampler.sv
// Samples a free-running ripple counter, filters settling glitches and accumulates its progress.
// Define RIPPLE_SAMPLER_SAT_EN for a saturating accumulator; otherwise it wraps.
module ripple_count_sampler
   import ripple_sampler_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEFAULT,
   parameter int unsigned ACC_W    = ACC_W_DEFAULT,
   parameter int unsigned STABLE_N = STABLE_N_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             clr,
   input  logic             snap_req,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_data,
   output logic [ACC_W-1:0] acc,
   output logic             delta_valid,
   output logic [CNT_W-1:0] delta,
   output logic             ovf
);

   localparam int unsigned RUN_W = $clog2(STABLE_N + 1);
   localparam int unsigned SUM_W = ACC_W + 1;
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_N);
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   logic [CNT_W-1:0] cnt_sync;
   logic [CNT_W-1:0] prev_q;
   logic [RUN_W-1:0] run_q, run_d;
   logic             stable;
   logic [CNT_W-1:0] diff;

   filt_state_e      filt_q, filt_d;
   logic [CNT_W-1:0] base_q, base_d;
   logic             accept;

   logic [SUM_W-1:0] sum;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             delta_valid_q;
   logic [CNT_W-1:0] delta_q, delta_d;

   snap_state_e      snap_q, snap_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;

   bit_sync2 #(
      .WIDTH(CNT_W)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (cnt_in),
      .q    (cnt_sync)
   );

   // Stability run length: restarts on any change, saturates once the value is trusted.
   always_comb begin
      run_d = run_q;
      if (cnt_sync != prev_q) begin
         run_d = '0;
      end else if (run_q != RUN_MAX) begin
         run_d = run_q + RUN_W'(1);
      end
   end

   assign stable = (run_q == RUN_MAX) && (cnt_sync == prev_q);
   assign diff   = cnt_sync - base_q;

   always_comb begin
      filt_d = filt_q;
      base_d = base_q;
      accept = 1'b0;
      case (filt_q)
         FiltInit: begin
            if (stable) begin
               base_d = cnt_sync;
               filt_d = FiltRun;
            end
         end
         FiltRun: begin
            if (stable && (cnt_sync != base_q)) begin
               accept = 1'b1;
               base_d = cnt_sync;
            end
         end
         default: filt_d = FiltInit;
      endcase
   end

   assign sum     = {1'b0, acc_q} + SUM_W'(diff);
   assign delta_d = accept ? diff : delta_q;

   // clr wins over a delta accepted in the same cycle; the delta is simply lost.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (clr) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (accept) begin
`ifdef RIPPLE_SAMPLER_SAT_EN
         if (sum >= {1'b0, ACC_MAX}) begin
            acc_d = ACC_MAX;
            ovf_d = 1'b1;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
`else
         acc_d = sum[ACC_W-1:0];
         if (sum[ACC_W]) begin
            ovf_d = 1'b1;
         end
`endif
      end
   end

   always_comb begin
      snap_d      = snap_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (snap_q)
         SnapIdle: begin
            if (snap_req) begin
               out_data_d  = acc_q;
               out_valid_d = 1'b1;
               snap_d      = SnapHold;
            end
         end
         SnapHold: begin
            if (out_ready) begin
               // Back-to-back: completing transfer and new capture share the cycle.
               if (snap_req) begin
                  out_data_d = acc_q;
               end else begin
                  out_valid_d = 1'b0;
                  snap_d      = SnapIdle;
               end
            end
         end
         default: begin
            out_valid_d = 1'b0;
            snap_d      = SnapIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q        <= '0;
         run_q         <= '0;
         filt_q        <= FiltInit;
         base_q        <= '0;
         acc_q         <= '0;
         ovf_q         <= 1'b0;
         delta_valid_q <= 1'b0;
         delta_q       <= '0;
         snap_q        <= SnapIdle;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
      end else begin
         prev_q        <= cnt_sync;
         run_q         <= run_d;
         filt_q        <= filt_d;
         base_q        <= base_d;
         acc_q         <= acc_d;
         ovf_q         <= ovf_d;
         delta_valid_q <= accept;
         delta_q       <= delta_d;
         snap_q        <= snap_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign acc         = acc_q;
   assign delta_valid = delta_valid_q;
   assign delta       = delta_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler with a delta/acc scoreboard.
module tb_ripple_count_sampler;

   localparam int unsigned CNT_W    = 4;
   localparam int unsigned ACC_W    = 16;
   localparam int unsigned STABLE_N = 2;

   logic             clk;
   logic             rst_n;
   logic [CNT_W-1:0] cnt_in;
   logic             clr;
   logic             snap_req;
   logic             out_ready;
   logic             out_valid;
   logic [ACC_W-1:0] out_data;
   logic [ACC_W-1:0] acc;
   logic             delta_valid;
   logic [CNT_W-1:0] delta;
   logic             ovf;

   typedef struct packed {
      logic [CNT_W-1:0] delta;
      logic [ACC_W-1:0] acc;
   } exp_t;

   exp_t             sb[$];
   int               vectors;
   int               miscompares;
   int               pulses;
   int               pulses_before;
   int               lat;
   logic [CNT_W-1:0] m_base;
   logic [ACC_W-1:0] m_acc;
   logic             m_ovf;
   logic [ACC_W-1:0] gap;

   ripple_count_sampler #(
      .CNT_W   (CNT_W),
      .ACC_W   (ACC_W),
      .STABLE_N(STABLE_N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_in     (cnt_in),
      .clr        (clr),
      .snap_req   (snap_req),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .acc        (acc),
      .delta_valid(delta_valid),
      .delta      (delta),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference accumulator: independent of the DUT's internal encoding.
   task automatic model_add(input logic [CNT_W-1:0] k);
      logic [ACC_W:0] s;
      s = {1'b0, m_acc} + (ACC_W + 1)'(k);
`ifdef RIPPLE_SAMPLER_SAT_EN
      if (s > 17'h0FFFF) begin
         m_acc = 16'hFFFF;
         m_ovf = 1'b1;
      end else begin
         m_acc = s[ACC_W-1:0];
      end
`else
      m_acc = s[ACC_W-1:0];
      if (s[ACC_W]) m_ovf = 1'b1;
`endif
   endtask

   task automatic step_nowait(input logic [CNT_W-1:0] k);
      exp_t e;
      m_base = m_base + k;
      cnt_in = m_base;
      model_add(k);
      e.delta = k;
      e.acc   = m_acc;
      sb.push_back(e);
   endtask

   task automatic step(input logic [CNT_W-1:0] k);
      step_nowait(k);
      tick(7);
   endtask

   // Scoreboard: every delta pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && delta_valid === 1'b1) begin
         pulses++;
         check("sb_pending", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("delta", 32'(delta), 32'(e.delta));
            check("delta_acc", 32'(acc), 32'(e.acc));
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      pulses      = 0;
      rst_n       = 1'b0;
      cnt_in      = '0;
      clr         = 1'b0;
      snap_req    = 1'b0;
      out_ready   = 1'b0;
      m_base      = '0;
      m_acc       = '0;
      m_ovf       = 1'b0;
      tick(3);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_acc", 32'(acc), 32'd0);
      check("rst_delta_valid", 32'(delta_valid), 32'd0);
      check("rst_delta", 32'(delta), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;

      // First stable value only loads base.
      cnt_in = 4'd3;
      m_base = 4'd3;
      tick(10);
      check("init_acc", 32'(acc), 32'd0);
      check("init_pulses", 32'(pulses), 32'd0);

      // Acceptance latency: pulse visible after the sixth edge from the drive point.
      step_nowait(4'd2);
      lat = 0;
      while (delta_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'd6);
      tick(2);
      check("acc_after_5", 32'(acc), 32'd2);

      step(4'd9);
      check("acc_base14", 32'(acc), 32'd11);
      step(4'd3);
      check("wrap_acc", 32'(acc), 32'd14);
      step(4'd4);
      check("acc_base5", 32'(acc), 32'd18);

      // One-cycle glitch to 7 must be ignored entirely.
      pulses_before = pulses;
      cnt_in = 4'd7;
      tick(1);
      cnt_in = 4'd5;
      tick(7);
      check("glitch_pulses", 32'(pulses), 32'(pulses_before));
      check("glitch_acc", 32'(acc), 32'd18);
      step(4'd1);
      check("post_glitch_acc", 32'(acc), 32'd19);

      step(4'd15);
      step(4'd15);
      step(4'd15);
      step(4'd2);
      check("acc_42", 32'(acc), 32'h42);

      // Snapshot held under backpressure.
      snap_req = 1'b1;
      tick(1);
      snap_req = 1'b0;
      check("snap_valid", 32'(out_valid), 32'd1);
      check("snap_data", 32'(out_data), 32'h42);
      tick(3);
      check("snap_hold_valid", 32'(out_valid), 32'd1);
      check("snap_hold_data", 32'(out_data), 32'h42);
      step(4'd1);
      snap_req = 1'b1;
      tick(1);
      snap_req = 1'b0;
      check("snap_ignored", 32'(out_data), 32'h42);
      check("snap_ignored_valid", 32'(out_valid), 32'd1);
      snap_req  = 1'b1;
      out_ready = 1'b1;
      tick(1);
      snap_req  = 1'b0;
      out_ready = 1'b0;
      check("snap_b2b_valid", 32'(out_valid), 32'd1);
      check("snap_b2b_data", 32'(out_data), 32'h43);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check("snap_drop", 32'(out_valid), 32'd0);

      // Climb to 0xFFFE, then cross the top.
      while (m_acc <= 16'hFFFE - 16'd15) step(4'd15);
      if (m_acc != 16'hFFFE) begin
         gap = 16'hFFFE - m_acc;
         step(gap[CNT_W-1:0]);
      end
      check("acc_fffe", 32'(acc), 32'hFFFE);
      check("ovf_before", 32'(ovf), 32'd0);
      step(4'd3);
`ifdef RIPPLE_SAMPLER_SAT_EN
      check("ovf_acc", 32'(acc), 32'hFFFF);
`else
      check("ovf_acc", 32'(acc), 32'h0001);
`endif
      check("ovf_flag", 32'(ovf), 32'd1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      m_acc = '0;
      m_ovf = 1'b0;
      check("clr_acc", 32'(acc), 32'd0);
      check("clr_ovf", 32'(ovf), 32'd0);

      // clr coinciding with acceptance drops the delta but still moves base.
      m_base = m_base + 4'd5;
      cnt_in = m_base;
      sb.push_back('{delta: 4'd5, acc: 16'd0});
      tick(5);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(2);
      check("clr_same_acc", 32'(acc), 32'd0);
      step(4'd2);
      check("clr_base_moved", 32'(acc), 32'd2);

      // Reset aborts a pending snapshot and re-enters INIT.
      snap_req = 1'b1;
      tick(1);
      snap_req = 1'b0;
      check("pre_abort_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_acc", 32'(acc), 32'd0);
      m_acc = '0;
      tick(2);
      rst_n = 1'b1;
      tick(8);
      check("reinit_acc", 32'(acc), 32'd0);
      step(4'd4);
      check("reinit_step_acc", 32'(acc), 32'd4);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
